// File: rtl/tff_div_pkg.sv
// tff_div_pkg: shared state encoding and period clamp for the toggle-cell divider sequencer
package tff_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int PMIN = 2;
endpackage

// File: rtl/tff_div_sequencer_if.sv
// tff_div_sequencer_if: config handshake, run control and divided-waveform outputs
// master drives cfg_valid/cfg_period/cfg_high/start/stop; slave drives cfg_ready/busy/out/tick/done
interface tff_div_sequencer_if #(parameter int WIDTH = 4);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_high;
  logic             start;
  logic             stop;
  logic             busy;
  logic             out;
  logic             tick;
  logic             done;
  modport master(output cfg_valid, cfg_period, cfg_high, start, stop,
                 input cfg_ready, busy, out, tick, done);
  modport slave(input cfg_valid, cfg_period, cfg_high, start, stop,
                output cfg_ready, busy, out, tick, done);
endinterface

// File: rtl/tff_div_sequencer_tcell.sv
// tcell: toggle flip-flop with synchronous clear that overrides toggling
// ports: clk, nrst (async active-low), t (toggle enable), clr (sync clear), q
module tcell (
  input  logic clk,
  input  logic nrst,
  input  logic t,
  input  logic clr,
  output logic q
);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) q <= 1'b0;
    else       q <= clr ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_div_sequencer.sv
// tff_div_sequencer: run/stop FSM sequencing a toggle-cell counter into a registered divided enable
// ports: clk, nrst (async active-low), bus (slave modport: cfg handshake, start/stop, busy/out/tick/done)
module tff_div_sequencer
  import tff_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                nrst,
  tff_div_sequencer_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, p_q, p_d, h_q, h_d;
  logic             out_q, tick_q, done_q, rdy_q;
  logic             fire, last, clr, en, run_d;
  always_comb begin
    fire    = bus.cfg_valid & rdy_q;
    p_d     = fire ? ((bus.cfg_period < WIDTH'(PMIN)) ? WIDTH'(PMIN) : bus.cfg_period) : p_q;
    h_d     = fire ? bus.cfg_high : h_q;
    last    = cnt_q == p_q - WIDTH'(1);
    state_d = state_q == IDLE ? (bus.start ? RUN : IDLE) :
              state_q == RUN  ? (bus.stop ? (last ? IDLE : DRAIN) : RUN) :
                                (last ? IDLE : DRAIN);
    // the counter restarts from zero both on wrap and when a run begins
    clr     = state_q == IDLE || last;
    en      = !clr;
    cnt_d   = clr ? '0 : cnt_q + WIDTH'(1);
    run_d   = state_d != IDLE;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic t;
    if (i == 0) begin : g_lsb
      assign t = en;
    end else begin : g_bit
      assign t = en & (&cnt_q[i-1:0]);
    end
    tcell u_cell (.clk(clk), .nrst(nrst), .t(t), .clr(clr), .q(cnt_q[i]));
  end
  // outputs come from next-state values so they line up with cnt of the same cycle
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      p_q     <= WIDTH'(PMIN);
      h_q     <= '0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      out_q   <= run_d && (cnt_d < h_d);
      tick_q  <= run_d && (cnt_d == p_d - WIDTH'(1));
      done_q  <= state_q != IDLE && state_d == IDLE;
      rdy_q   <= state_d == IDLE;
    end
  assign bus.cfg_ready = rdy_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.out       = out_q;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_tff_div_sequencer.sv
// tb_tff_div_sequencer: directed self-checking bench for tff_div_sequencer
module tb_tff_div_sequencer;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  tff_div_sequencer_if #(.WIDTH(4)) bus ();
  tff_div_sequencer #(.WIDTH(4)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [3:0] p, input logic [3:0] h);
    bus.cfg_valid = 1'b1; bus.cfg_period = p; bus.cfg_high = h;
    step();
    bus.cfg_valid = 1'b0;
  endtask
  task automatic start_run();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic run_check(input string tag, input int p, input int h, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "_out"}, bus.out, ((k % p) < h) ? 1 : 0);
      chk({tag, "_tick"}, bus.tick, ((k % p) == p - 1) ? 1 : 0);
      chk({tag, "_busy"}, bus.busy, 1);
      step();
    end
  endtask
  task automatic stop_run(input string tag);
    int n = 0;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    while (!bus.done && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    step();
    chk({tag, "_done_clr"}, bus.done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    #12;
    chk("rst_out", bus.out, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cfg_ready, 0);
    @(negedge clk) nrst = 1'b1;
    step();
    chk("rel_ready", bus.cfg_ready, 1);
    cfg(4'd5, 4'd2);
    start_run();
    run_check("p5h2", 5, 2, 10);
    step();
    chk("pre_stop_out", bus.out, 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("drain2_out", bus.out, 0);
    chk("drain2_busy", bus.busy, 1);
    chk("drain2_done", bus.done, 0);
    step();
    chk("drain3_tick", bus.tick, 0);
    step();
    chk("drain4_tick", bus.tick, 1);
    chk("drain4_busy", bus.busy, 1);
    step();
    chk("drain_done", bus.done, 1);
    chk("drain_busy", bus.busy, 0);
    chk("drain_out", bus.out, 0);
    chk("drain_ready", bus.cfg_ready, 1);
    step();
    chk("drain_done_clr", bus.done, 0);
    cfg(4'd4, 4'd1);
    start_run();
    run_check("p4h1", 4, 1, 3);
    chk("last_tick", bus.tick, 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("fast_done", bus.done, 1);
    chk("fast_busy", bus.busy, 0);
    chk("fast_out", bus.out, 0);
    chk("fast_tick", bus.tick, 0);
    step();
    chk("fast_done_clr", bus.done, 0);
    cfg(4'd0, 4'd0);
    start_run();
    run_check("clamp", 2, 0, 6);
    stop_run("clamp_stop");
    cfg(4'd3, 4'd7);
    start_run();
    run_check("hhigh", 3, 7, 6);
    stop_run("hhigh_stop");
    bus.cfg_valid = 1'b1; bus.cfg_period = 4'd6; bus.cfg_high = 4'd3; bus.start = 1'b1;
    step();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    run_check("same", 6, 3, 6);
    bus.cfg_valid = 1'b1; bus.cfg_period = 4'd2; bus.cfg_high = 4'd0;
    chk("run_ready", bus.cfg_ready, 0);
    run_check("ignore", 6, 3, 6);
    bus.cfg_valid = 1'b0;
    stop_run("same_stop");
    start_run();
    run_check("persist", 6, 3, 6);
    stop_run("persist_stop");
    cfg(4'd7, 4'd5);
    start_run();
    step(); step(); step();
    chk("mid_out", bus.out, 1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_out", bus.out, 0);
    chk("arst_tick", bus.tick, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_ready", bus.cfg_ready, 0);
    @(negedge clk) nrst = 1'b1;
    step();
    chk("post_ready", bus.cfg_ready, 1);
    chk("post_busy", bus.busy, 0);
    for (int k = 0; k < 4; k++) begin
      chk("post_done", bus.done, 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
